// File: rtl/alu_result_fifo.sv
// alu_result_fifo: first-word-fall-through FIFO for ALU results.
// Each entry holds {overflow, carry, result[7:0]}.
// Optional build macro RESULT_PARITY_EN adds a stored parity bit per entry.
// The parity bit is exposed on the out_parity port.
// Full and empty flags are derived from the occupancy counter, so pointers
// need no extra wrap bit.
module alu_result_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [7:0]               in_result,
  input  logic                     in_carry,
  input  logic                     in_overflow,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_result,
  output logic                     out_carry,
  output logic                     out_overflow,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
`ifdef RESULT_PARITY_EN
  output logic                     out_parity,
`endif
  output logic                     drop_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
`ifdef RESULT_PARITY_EN
  localparam int EW = 11;
`else
  localparam int EW = 10;
`endif

`ifdef RESULT_PARITY_EN
  // Even-parity bit over a 10-bit payload.
  function automatic logic parity10(input logic [9:0] d);
    return ^d;
  endfunction
`endif

  logic [EW-1:0] mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          drop_err_r;

  logic          full_s;
  logic          empty_s;
  logic          push_s;
  logic          pop_s;
  logic [EW-1:0] entry_s;
  logic [EW-1:0] head_s;

  assign full_s  = (count_r == CW'(DEPTH));
  assign empty_s = (count_r == {CW{1'b0}});

  // A full FIFO refuses pushes even when a pop happens in the same cycle.
  assign push_s  = ena && in_valid && !full_s && !flush;
  assign pop_s   = ena && !empty_s && out_ready && !flush;

`ifdef RESULT_PARITY_EN
  assign entry_s = {parity10({in_overflow, in_carry, in_result}),
                    in_overflow, in_carry, in_result};
`else
  assign entry_s = {in_overflow, in_carry, in_result};
`endif

  assign head_s       = mem_r[rd_ptr_r];
  assign in_ready     = !full_s;
  assign out_valid    = !empty_s;
  assign out_result   = head_s[7:0];
  assign out_carry    = head_s[8];
  assign out_overflow = head_s[9];
`ifdef RESULT_PARITY_EN
  assign out_parity   = head_s[10];
`endif
  assign count        = count_r;
  assign drop_err     = drop_err_r;

  // Entry storage: written on push, deliberately not reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= entry_s;
    end
  end

  // Pointers, occupancy and sticky drop flag; flush overrides push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {CW{1'b0}};
      drop_err_r <= 1'b0;
    end else if (ena) begin
      if (flush) begin
        wr_ptr_r   <= {AW{1'b0}};
        rd_ptr_r   <= {AW{1'b0}};
        count_r    <= {CW{1'b0}};
        drop_err_r <= 1'b0;
      end else begin
        if (push_s) begin
          wr_ptr_r <= wr_ptr_r + AW'(1);
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + AW'(1);
        end
        case ({push_s, pop_s})
          2'b10:   count_r <= count_r + CW'(1);
          2'b01:   count_r <= count_r - CW'(1);
          default: count_r <= count_r;
        endcase
        if (in_valid && full_s) begin
          drop_err_r <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_result_fifo.sv
// Self-checking bench for alu_result_fifo (DEPTH=4).
// Directed scenarios are followed by a randomized phase.
// Expected values come from a queue-based reference model.
module tb_alu_result_fifo;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ena;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_result;
  logic          in_carry;
  logic          in_overflow;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_result;
  logic          out_carry;
  logic          out_overflow;
  logic          flush;
  logic [CW-1:0] count;
  logic          drop_err;
`ifdef RESULT_PARITY_EN
  logic          out_parity;
`endif

  int tests = 0;
  int fails = 0;

  // Reference model: queue of {overflow, carry, result} entries.
  logic [9:0] q[$];
  logic       m_drop;

  alu_result_fifo #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .in_carry     (in_carry),
    .in_overflow  (in_overflow),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_carry    (out_carry),
    .out_overflow (out_overflow),
    .flush        (flush),
    .count        (count),
`ifdef RESULT_PARITY_EN
    .out_parity   (out_parity),
`endif
    .drop_err     (drop_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic e, input logic iv, input logic [7:0] r,
                       input logic c, input logic o, input logic ordy, input logic fl);
    ena = e; in_valid = iv; in_result = r; in_carry = c; in_overflow = o;
    out_ready = ordy; flush = fl;
  endtask

  // Apply the FIFO rules to the model for the inputs present at the next edge.
  task automatic model_edge();
    logic full;
    full = (q.size() == DEPTH);
    if (ena) begin
      if (flush) begin
        q.delete();
        m_drop = 1'b0;
      end else begin
        if (in_valid && full) m_drop = 1'b1;
        if (out_ready && q.size() > 0) void'(q.pop_front());
        if (in_valid && !full) q.push_back({in_overflow, in_carry, in_result});
      end
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ":count"}, 32'(count), 32'(q.size()));
    chk({tag, ":out_valid"}, 32'(out_valid), 32'(q.size() > 0));
    chk({tag, ":in_ready"}, 32'(in_ready), 32'(q.size() < DEPTH));
    chk({tag, ":drop_err"}, 32'(drop_err), 32'(m_drop));
    if (q.size() > 0) begin
      chk({tag, ":out_result"}, 32'(out_result), 32'(q[0][7:0]));
      chk({tag, ":out_carry"}, 32'(out_carry), 32'(q[0][8]));
      chk({tag, ":out_overflow"}, 32'(out_overflow), 32'(q[0][9]));
`ifdef RESULT_PARITY_EN
      chk({tag, ":out_parity"}, 32'(out_parity), 32'(^q[0]));
`endif
    end
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_state(tag);
  endtask

  initial begin
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    m_drop = 1'b0;
    rst_n = 1'b0;
    #12;
    chk("reset:count", 32'(count), 32'd0);
    chk("reset:in_ready", 32'(in_ready), 32'd1);
    chk("reset:out_valid", 32'(out_valid), 32'd0);
    chk("reset:drop_err", 32'(drop_err), 32'd0);
    rst_n = 1'b1;
    #1;

    // Single push with carry, consumer stalled: visible one cycle later.
    drive(1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
    tick("push1");
    chk("push1:out_valid", 32'(out_valid), 32'd1);
    chk("push1:out_result", 32'(out_result), 32'h3C);
    chk("push1:out_carry", 32'(out_carry), 32'd1);
    chk("push1:count", 32'(count), 32'd1);
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    tick("flush0");

    // Fill to full, then a refused push sets drop_err.
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
      tick("fill");
    end
    drive(1'b1, 1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("full:in_ready", 32'(in_ready), 32'd0);
    tick("overfill");
    chk("overfill:drop_err", 32'(drop_err), 32'd1);
    chk("overfill:count", 32'(count), 32'd4);

    // Disabled block ignores push, pop and flush.
    drive(1'b0, 1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 1'b1);
    tick("ena0");
    chk("ena0:count", 32'(count), 32'd4);
    chk("ena0:drop_err", 32'(drop_err), 32'd1);

    // Drain in order.
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("drain:out_result", 32'(out_result), 32'(i));
      tick("drain");
    end
    chk("drained:out_valid", 32'(out_valid), 32'd0);

    // Steady push/pop pairs at occupancy 2 across pointer wrap.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 8'(8'hA0 + i), 1'b1, 1'b0, 1'b0, 1'b0);
      tick("pre2");
    end
    for (int k = 0; k < 9; k++) begin
      drive(1'b1, 1'b1, 8'(8'hA2 + k), 1'b0, 1'b1, 1'b1, 1'b0);
      chk("pair:out_result", 32'(out_result), 32'(8'hA0 + k));
      tick("pair");
      chk("pair:count", 32'(count), 32'd2);
    end

    // Flush at 3 entries beats concurrent push and pop and clears drop_err.
    drive(1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0);
    tick("to3");
    chk("to3:drop_err", 32'(drop_err), 32'd1);
    drive(1'b1, 1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 1'b1);
    tick("flush3");
    chk("flush3:count", 32'(count), 32'd0);
    chk("flush3:out_valid", 32'(out_valid), 32'd0);
    chk("flush3:drop_err", 32'(drop_err), 32'd0);

    // Asynchronous reset between edges with 2 entries.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0, 1'b0);
      tick("pre_rst");
    end
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst:count", 32'(count), 32'd0);
    chk("arst:in_ready", 32'(in_ready), 32'd1);
    chk("arst:out_valid", 32'(out_valid), 32'd0);
    q.delete();
    m_drop = 1'b0;
    #1;
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0);
    tick("post_rst");
    chk("post_rst:out_result", 32'(out_result), 32'h55);
    chk("post_rst:count", 32'(count), 32'd1);

`ifdef RESULT_PARITY_EN
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    tick("pflush");
    drive(1'b1, 1'b1, 8'h07, 1'b0, 1'b1, 1'b0, 1'b0);
    tick("parity");
    chk("parity:out_parity", 32'(out_parity), 32'd0);
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 7) != 0), 1'($urandom), 8'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 31) == 0));
      tick("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_result_fifo.md
ALU_RESULT_FIFO -- requirements
Module: alu_result_fifo

Interface
REQ-001 Parameter DEPTH, 4, number of result entries; power of two, 2..16.
REQ-002 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port ena  input  1  block enable; when 0, no push, pop or flush takes effect.
REQ-005 Port in_valid  input  1  upstream ALU result present this cycle.
REQ-006 Port in_ready  output  1  FIFO can accept a push (combinational, equals !full).
REQ-007 Port in_result  input  8  ALU result byte.
REQ-008 Port in_carry  input  1  ALU carry/borrow flag.
REQ-009 Port in_overflow  input  1  ALU signed-overflow flag.
REQ-010 Port out_valid  output  1  head entry available (combinational, equals !empty).
REQ-011 Port out_ready  input  1  consumer accepts the head entry this cycle.
REQ-012 Port out_result  output  8  head entry result byte.
REQ-013 Port out_carry  output  1  head entry carry flag.
REQ-014 Port out_overflow  output  1  head entry overflow flag.
REQ-015 Port flush  input  1  synchronous clear of all entries.
REQ-016 Port count  output  clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-017 Port drop_err  output  1  sticky: a push was attempted while full.

Function
REQ-018 Push occurs when ena && in_valid && in_ready && !flush; the 10-bit entry {overflow,carry,result} is written at the write pointer.
REQ-019 Pop occurs when ena && out_valid && out_ready && !flush; the read pointer advances.
REQ-020 Outputs are first-word-fall-through: out_* reflect the entry at the read pointer with no extra register stage.
REQ-021 Latency is 1 cycle: a push into an empty FIFO makes out_valid=1 on the following cycle.
REQ-022 Pointers are clog2(DEPTH) bits wide and wrap from DEPTH-1 to 0 with no gap.
REQ-023 Simultaneous push and pop: both take effect and count is unchanged.
REQ-024 Full (count==DEPTH): in_ready=0; no push and no pass-through, even if a pop occurs in the same cycle.
REQ-025 Empty (count==0): out_valid=0; out_* hold the stale entry value and are don't-care.
REQ-026 ena && in_valid && !in_ready sets drop_err; it stays set until flush or reset.
REQ-027 Flush (with ena=1): pointers and count go to 0 and drop_err clears on the next edge; flush beats any concurrent push or pop.
REQ-028 With ena=0: all state holds and drop_err cannot set.

Reset
REQ-029 rst_n low asynchronously forces pointers=0, count=0, drop_err=0, hence in_ready=1 and out_valid=0.
REQ-030 Storage contents are not reset; out_* are don't-care while empty.
REQ-031 Reset asserted mid-transfer discards all entries; the first push after release behaves as a push into an empty FIFO.

Configuration
REQ-032 Macro RESULT_PARITY_EN adds an output out_parity (1 bit) equal to the XOR of the head entry's 10 bits; parity is computed at push and stored as an 11th entry bit.
REQ-033 Without RESULT_PARITY_EN, out_parity and its storage bit are absent; all other behaviour is identical.

Verification
REQ-034 Reset, then push 0x3C with carry=1, out_ready=0 -> next cycle out_valid=1, out_result=0x3C, out_carry=1, count=1.
REQ-035 Push 0x01..0x04 (DEPTH=4), then in_valid with 0x05 -> in_ready=0, drop_err=1, count=4; then drain -> outputs 0x01,0x02,0x03,0x04 in order.
REQ-036 Run 9 push/pop pairs with count=2 held steady -> data order preserved across pointer wrap, count stays 2.
REQ-037 With 3 entries, flush+in_valid+out_ready in one cycle -> next cycle count=0, out_valid=0, drop_err=0.
REQ-038 With 2 entries, pulse rst_n low asynchronously between edges -> count=0 and in_ready=1 immediately, without waiting for an edge.
REQ-039 With RESULT_PARITY_EN defined, push 0x07 with overflow=1, carry=0 -> out_parity=0 (four ones, even); without the macro, the design compiles with no out_parity port.
